md_sched: RTL and testbench

- Multiply/divide sequencer for the pipelined MIPS datapath; sits in the EX stage beside the ALU.
- Owns the HI/LO registers and models the multi-cycle latency of mult/multu/div/divu.
- Raises a stall request so the hazard logic can freeze IF/ID while a HI/LO-dependent instruction waits.
- Handles mthi/mtlo writes directly.

---
 rtl/md_sched_if.sv | 16 +
 rtl/md_sched.sv | 160 ++++++++++++++++
 tb/tb_md_sched.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/md_sched_if.sv
// EX-stage handshake between the pipeline and the multiply/divide sequencer.
// The master drives the operation request and samples HI/LO, busy and the stall request.
interface md_sched_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        md_id;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        stall;

    modport master (output start, op, a, b, md_id, input hi, lo, busy, stall);
    modport slave  (input start, op, a, b, md_id, output hi, lo, busy, stall);
endinterface

// File: rtl/md_sched.sv
// Multiply/divide sequencer: owns HI/LO, models mult/div latency and requests IF/ID stalls.
// The result is computed at the launch edge and held pending until the busy countdown expires.
module md_sched #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic      clk,
    input  logic      rst,
    md_sched_if.slave bus
);
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES + 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_MULT = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] CNT_DIV  = CW'(DIV_CYCLES);

    typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

    state_t        state_r, state_nxt_s;
    logic [CW-1:0] cnt_r, cnt_nxt_s;
    logic [31:0]   hi_r, lo_r, pend_hi_r, pend_lo_r;
    logic          pend_wr_r, busy_r, stall_s;
    logic          is_md_s, is_div_s, is_signed_s, launch_s, done_s;
    logic [63:0]   result_s;

    // Sign- or zero-extend to 64 bits; the low 64 bits of the product are then correct for both.
    function automatic logic [63:0] md_mul(input logic [31:0] x, input logic [31:0] y, input logic sgn);
        logic [63:0] xe;
        logic [63:0] ye;
        xe = {(sgn ? {32{x[31]}} : 32'd0), x};
        ye = {(sgn ? {32{y[31]}} : 32'd0), y};
        return xe * ye;
    endfunction

    // Magnitude division with sign fix-up; 0x80000000 / -1 wraps naturally to 0x80000000 rem 0.
    function automatic logic [63:0] md_div(input logic [31:0] x, input logic [31:0] y, input logic sgn);
        logic [31:0] xm;
        logic [31:0] ym;
        logic [31:0] q;
        logic [31:0] r;
        xm = (sgn && x[31]) ? (32'd0 - x) : x;
        ym = (sgn && y[31]) ? (32'd0 - y) : y;
        if (ym == 32'd0) begin
            q = 32'd0;
            r = 32'd0;
        end else begin
            q = xm / ym;
            r = xm % ym;
        end
        if (sgn && (x[31] ^ y[31])) begin
            q = 32'd0 - q;
        end else begin
            q = q;
        end
        if (sgn && x[31]) begin
            r = 32'd0 - r;
        end else begin
            r = r;
        end
        return {r, q};
    endfunction

    // Decode the EX-stage request and compute the result a launch would capture.
    always_comb begin
        is_md_s     = bus.start & ~bus.op[2];
        is_div_s    = bus.op[1];
        is_signed_s = ~bus.op[0];
        launch_s    = (state_r == S_IDLE) & is_md_s;
        done_s      = (state_r == S_RUN) & (cnt_r == CNT_ONE);
        if (is_div_s) begin
            result_s = md_div(bus.a, bus.b, is_signed_s);
        end else begin
            result_s = md_mul(bus.a, bus.b, is_signed_s);
        end
    end

    // State register: FSM state, countdown and the registered busy flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_IDLE;
            cnt_r   <= '0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            busy_r  <= (state_nxt_s == S_RUN);
        end
    end

    // Next-state logic: requests arriving while RUN are ignored.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            S_IDLE: begin
                if (launch_s) begin
                    state_nxt_s = S_RUN;
                    cnt_nxt_s   = is_div_s ? CNT_DIV : CNT_MULT;
                end else begin
                    state_nxt_s = S_IDLE;
                    cnt_nxt_s   = cnt_r;
                end
            end
            S_RUN: begin
                cnt_nxt_s = cnt_r - CNT_ONE;
                if (cnt_r == CNT_ONE) begin
                    state_nxt_s = S_IDLE;
                end else begin
                    state_nxt_s = S_RUN;
                end
            end
            default: begin
                state_nxt_s = S_IDLE;
                cnt_nxt_s   = '0;
            end
        endcase
    end

    // HI/LO and pending result; a divide by zero completes without writing back.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_r      <= 32'd0;
            lo_r      <= 32'd0;
            pend_hi_r <= 32'd0;
            pend_lo_r <= 32'd0;
            pend_wr_r <= 1'b0;
        end else begin
            if (launch_s) begin
                pend_hi_r <= result_s[63:32];
                pend_lo_r <= result_s[31:0];
                pend_wr_r <= ~(is_div_s & (bus.b == 32'd0));
            end else begin
                pend_hi_r <= pend_hi_r;
                pend_lo_r <= pend_lo_r;
                pend_wr_r <= pend_wr_r;
            end
            if (done_s && pend_wr_r) begin
                hi_r <= pend_hi_r;
                lo_r <= pend_lo_r;
            end else if ((state_r == S_IDLE) && bus.start && (bus.op == 3'b100)) begin
                hi_r <= bus.a;
            end else if ((state_r == S_IDLE) && bus.start && (bus.op == 3'b101)) begin
                lo_r <= bus.a;
            end else begin
                hi_r <= hi_r;
                lo_r <= lo_r;
            end
        end
    end

    // Output logic: stall is combinational so the hazard unit sees it in the launch cycle.
    always_comb begin
        stall_s = bus.md_id & (busy_r | is_md_s);
    end

    assign bus.hi    = hi_r;
    assign bus.lo    = lo_r;
    assign bus.busy  = busy_r;
    assign bus.stall = stall_s;
endmodule

// File: tb/tb_md_sched.sv
// Directed bench for md_sched: table of single operations plus hand-built sequences
// for requests during RUN and asynchronous reset in the middle of a divide.
module tb_md_sched;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    md_sched_if bus();
    md_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        md_id;
        logic        exp_stall;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          exp_cyc;
    } vec_t;

    vec_t        vecs[16];
    int          n_checks = 0;
    int          n_pass = 0;
    logic [31:0] mdl_hi = 32'd0;
    logic [31:0] mdl_lo = 32'd0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Issue one op, then follow the busy period while holding md_id.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic md_id, input logic exp_stall,
                          input logic [31:0] ehi, input logic [31:0] elo, input int ecyc);
        int cyc;
        @(negedge clk);
        bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b; bus.md_id = md_id;
        #1;
        check({tag, " issue stall"}, {63'd0, bus.stall}, {63'd0, exp_stall});
        check({tag, " issue busy"}, {63'd0, bus.busy}, 64'd0);
        check({tag, " issue hilo"}, {bus.hi, bus.lo}, {mdl_hi, mdl_lo});
        @(negedge clk);
        bus.start = 1'b0; bus.op = 3'b110; bus.a = 32'd0; bus.b = 32'd0;
        cyc = 0;
        #1;
        while (bus.busy === 1'b1 && cyc < 40) begin
            cyc++;
            check($sformatf("%s hold c%0d", tag, cyc), {bus.hi, bus.lo}, {mdl_hi, mdl_lo});
            check($sformatf("%s busy stall c%0d", tag, cyc), {63'd0, bus.stall}, {63'd0, md_id});
            @(negedge clk);
            #1;
        end
        check({tag, " busy cycles"}, 64'(cyc), 64'(ecyc));
        check({tag, " result"}, {bus.hi, bus.lo}, {ehi, elo});
        check({tag, " stall after"}, {63'd0, bus.stall}, 64'd0);
        mdl_hi = ehi;
        mdl_lo = elo;
        bus.md_id = 1'b0;
    endtask

    initial begin
        int cyc;
        vecs[0]  = '{3'b000, 32'hFFFFFFFD, 32'h00000005, 1'b1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFF1, 5};
        vecs[1]  = '{3'b001, 32'hFFFFFFFF, 32'h00000002, 1'b0, 1'b0, 32'h00000001, 32'hFFFFFFFE, 5};
        vecs[2]  = '{3'b010, 32'hFFFFFFF9, 32'h00000002, 1'b1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[3]  = '{3'b011, 32'hFFFFFFF9, 32'h00000002, 1'b0, 1'b0, 32'h00000001, 32'h7FFFFFFC, 10};
        vecs[4]  = '{3'b010, 32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b1, 32'h00000000, 32'h80000000, 10};
        vecs[5]  = '{3'b100, 32'h12345678, 32'h00000000, 1'b1, 1'b0, 32'h12345678, 32'h80000000, 0};
        vecs[6]  = '{3'b101, 32'h12345678, 32'h00000000, 1'b1, 1'b0, 32'h12345678, 32'h12345678, 0};
        vecs[7]  = '{3'b010, 32'h00000005, 32'h00000000, 1'b1, 1'b1, 32'h12345678, 32'h12345678, 10};
        vecs[8]  = '{3'b110, 32'hFFFFFFFF, 32'h00000003, 1'b1, 1'b0, 32'h12345678, 32'h12345678, 0};
        vecs[9]  = '{3'b111, 32'hFFFFFFFF, 32'h00000003, 1'b1, 1'b0, 32'h12345678, 32'h12345678, 0};
        vecs[10] = '{3'b000, 32'h00000007, 32'hFFFFFFFE, 1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFF2, 5};
        vecs[11] = '{3'b011, 32'h00000064, 32'h00000007, 1'b0, 1'b0, 32'h00000002, 32'h0000000E, 10};
        vecs[12] = '{3'b010, 32'h00000007, 32'hFFFFFFFE, 1'b1, 1'b1, 32'h00000001, 32'hFFFFFFFD, 10};
        vecs[13] = '{3'b010, 32'hFFFFFFF8, 32'hFFFFFFFD, 1'b0, 1'b0, 32'hFFFFFFFE, 32'h00000002, 10};
        vecs[14] = '{3'b001, 32'h00010000, 32'h00010000, 1'b1, 1'b1, 32'h00000001, 32'h00000000, 5};
        vecs[15] = '{3'b011, 32'h00000005, 32'h00000000, 1'b0, 1'b0, 32'h00000001, 32'h00000000, 10};

        rst = 1'b1;
        bus.start = 1'b0; bus.op = 3'b110; bus.a = 32'd0; bus.b = 32'd0; bus.md_id = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("reset hilo", {bus.hi, bus.lo}, 64'd0);
        check("reset busy", {63'd0, bus.busy}, 64'd0);
        check("reset stall idle", {63'd0, bus.stall}, 64'd0);
        bus.start = 1'b1; bus.op = 3'b000;
        #1;
        check("reset stall comb", {63'd0, bus.stall}, 64'd1);
        bus.start = 1'b0; bus.op = 3'b110; bus.md_id = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].md_id,
                   vecs[i].exp_stall, vecs[i].exp_hi, vecs[i].exp_lo, vecs[i].exp_cyc);
        end

        // Requests during RUN must be ignored: mult 2*3 with mthi and div attempted mid-flight.
        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'b000; bus.a = 32'd2; bus.b = 32'd3; bus.md_id = 1'b0;
        @(negedge clk);
        bus.start = 1'b0; bus.op = 3'b110;
        cyc = 0;
        #1;
        while (bus.busy === 1'b1 && cyc < 40) begin
            cyc++;
            @(negedge clk);
            if (cyc == 2) begin
                bus.start = 1'b1; bus.op = 3'b100; bus.a = 32'hDEADBEEF;
            end else if (cyc == 3) begin
                bus.start = 1'b1; bus.op = 3'b010; bus.a = 32'd100; bus.b = 32'd7;
            end else begin
                bus.start = 1'b0; bus.op = 3'b110;
            end
            #1;
        end
        bus.start = 1'b0; bus.op = 3'b110;
        check("run ignore cycles", 64'(cyc), 64'd5);
        check("run ignore result", {bus.hi, bus.lo}, {32'h00000000, 32'h00000006});
        mdl_hi = 32'h00000000;
        mdl_lo = 32'h00000006;

        run_op("pre mthi", 3'b100, 32'hAAAA5555, 32'd0, 1'b0, 1'b0, 32'hAAAA5555, 32'h00000006, 0);
        run_op("pre mtlo", 3'b101, 32'h5555AAAA, 32'd0, 1'b1, 1'b0, 32'hAAAA5555, 32'h5555AAAA, 0);

        // Asynchronous reset in busy cycle 4 of a divide.
        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'b010; bus.a = 32'd100; bus.b = 32'd7; bus.md_id = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; bus.op = 3'b110;
        repeat (3) @(negedge clk);
        #1;
        check("mid div busy", {63'd0, bus.busy}, 64'd1);
        check("mid div hilo", {bus.hi, bus.lo}, {32'hAAAA5555, 32'h5555AAAA});
        #1;
        rst = 1'b1;
        #1;
        check("async rst busy", {63'd0, bus.busy}, 64'd0);
        check("async rst hilo", {bus.hi, bus.lo}, 64'd0);
        check("async rst stall", {63'd0, bus.stall}, 64'd0);
        #1;
        rst = 1'b0;
        bus.md_id = 1'b0;
        mdl_hi = 32'd0;
        mdl_lo = 32'd0;
        run_op("post rst mult", 3'b000, 32'd4, 32'd5, 1'b1, 1'b1, 32'h00000000, 32'h00000014, 5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
